regfile_mp: RTL
===============

Name: regfile_mp

Overview:
Parametrised multi-read-port register file for the RV32IC decode stage, replacing the single-port synchronous-read regfile.
- NUM_RD independent registered read ports with write-to-read bypass.
- Optional hardwired-zero x0.
- Pending-write scoreboard so decode can detect RAW hazards on in-flight destination registers.
- Contents clear on reset; no file preload.

Parameters:
ADDR_WIDTH, 5, register index width
DATA_WIDTH, 32, register word width
NUM_REGS, 32, implemented registers (must be <= 2**ADDR_WIDTH)
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
BYPASS, 1, 1 = same-cycle write data forwarded to a matching read

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
we  input  1  write enable
waddr  input  ADDR_WIDTH  write index
wdata  input  DATA_WIDTH  write data
re  input  NUM_RD  per-port read enable
raddr  input  NUM_RD*ADDR_WIDTH  packed read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
rdata  output  NUM_RD*DATA_WIDTH  packed registered read data
rbusy  output  NUM_RD  registered pending flag for each read index
claim_en  input  1  mark claim_addr as having an in-flight producer
claim_addr  input  ADDR_WIDTH  destination being claimed

Behaviour:
- Reset (rst_n low, asynchronous): all NUM_REGS registers = 0, all pending bits = 0, rdata = 0, rbusy = 0. Release is synchronous to clk: first update occurs on the first rising edge with rst_n high.
- Write: on the edge with we=1, waddr valid, waddr < NUM_REGS and not (ZERO_REG and waddr==0), RAM[waddr] <= wdata. Otherwise the write is dropped.
- Write side effect: any accepted write also clears pending[waddr].
- Read latency is 1 cycle. On the edge with re[i]=1, rdata[i] <= selected value:
  - 0 if raddr_i >= NUM_REGS, or if ZERO_REG and raddr_i==0.
  - Else wdata if BYPASS and the write is accepted with waddr==raddr_i.
  - Else RAM[raddr_i], the pre-write value.
- BYPASS=0: a same-address read returns the old value.
- re[i]=0: rdata[i] and rbusy[i] hold their previous values.
- Read-port independence: ports are fully independent. Several ports may read the same index; every port sees the same bypass result.
- Scoreboard:
  - pending[NUM_REGS-1:0] flops.
  - claim_en=1 with a valid, non-zero (if ZERO_REG) claim_addr sets pending[claim_addr].
  - An accepted write clears pending[waddr].
  - Same edge, same address, claim and write: claim wins, bit ends at 1 (new producer supersedes the retiring one).
  - Same edge, different addresses: both take effect.
  - Claiming an already-pending register keeps it at 1. No count is kept; one outstanding producer per register is decoder policy.
- rbusy[i] on a read edge = next-state pending[raddr_i]. It reflects this cycle's write-clear and claim-set, and is 0 for out-of-range or zero register.
- Reset asserted mid-operation: all state clears immediately, including pending bits; in-flight write or claim is lost.
- Out-of-range indices (NUM_REGS < 2**ADDR_WIDTH): reads return 0 with rbusy 0; writes and claims ignored.

Decomposition:
- Package regfile_pkg:
  - localparam defaults (RF_ADDR_WIDTH=5, RF_DATA_WIDTH=32, RF_NUM_REGS=32).
  - typedef rf_addr_t (logic [RF_ADDR_WIDTH-1:0]) and rf_word_t (logic [RF_DATA_WIDTH-1:0]).
  - constant RF_ZERO_IDX = 0.
- Sub-module regfile_read_port, instantiated NUM_RD times via generate. It contains:
  - Index range/zero check.
  - RAM and pending mux.
  - Bypass compare.
  - Registered rdata/rbusy with enable.
- Top module owns the storage array, pending vector, write/claim decode and the claim-over-clear priority.

Test Plan:
- Reset then read every index on all ports -> rdata=0, rbusy=0. Assert rst_n low mid-stream after writing x5=0xDEADBEEF -> next read of x5 returns 0.
- Write x3=0x12345678; next cycle read x3 on port0 and port1 -> both 0x12345678 one cycle after re.
- Same-edge we waddr=7 wdata=0xA5A5A5A5 and re raddr=7 -> BYPASS=1: rdata=0xA5A5A5A5. BYPASS=0: old x7 value; following read returns 0xA5A5A5A5.
- Write x0=0xFFFFFFFF, claim x0, read x0 -> rdata=0, rbusy=0 (ZERO_REG=1).
- Scoreboard sequence:
  - Claim x9, then read x9 -> rbusy=1.
  - Write x9=0x55 -> same-edge read gives rbusy=0, rdata=0x55.
  - Claim x9 and write x9 on the same edge -> read shows rbusy=1.
- NUM_REGS=16: write and claim x20, read x20 -> rdata=0, rbusy=0, no other register altered. re=0 for 3 cycles -> rdata stable.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults, types and index helpers for the multi-port register file.
package regfile_pkg;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_NUM_REGS   = 32;

  typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
  typedef logic [RF_DATA_WIDTH-1:0] rf_word_t;

  // Index of the architectural zero register.
  localparam int unsigned RF_ZERO_IDX = 0;

  // An index refers to real, writable storage only when it is implemented
  // and is not the hardwired zero register.
  function automatic logic rf_index_ok(input int unsigned idx,
                                       input int unsigned num_regs,
                                       input bit          zero_reg);
    return (idx < num_regs) && !(zero_reg && (idx == RF_ZERO_IDX));
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: range/zero check, storage and pending mux,
// write-to-read bypass, and enable-gated output registers.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NUM_REGS   = RF_NUM_REGS,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 re,
  input  logic [ADDR_WIDTH-1:0]                raddr,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  mem,
  input  logic [NUM_REGS-1:0]                  pending_nxt,
  input  logic                                 wr_ok,
  input  logic [ADDR_WIDTH-1:0]                waddr,
  input  logic [DATA_WIDTH-1:0]                wdata,
  output logic [DATA_WIDTH-1:0]                rdata,
  output logic                                 rbusy
);

  logic                  idx_ok;
  logic                  bypass_hit;
  logic [DATA_WIDTH-1:0] ram_word;
  logic                  ram_busy;
  logic [DATA_WIDTH-1:0] rdata_sel;
  logic                  rbusy_sel;

  // Pick the stored word and the post-edge pending bit for this index.
  // A compare per entry avoids indexing with a wider-than-needed address.
  always_comb begin
    ram_word = '0;
    ram_busy = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (raddr == ADDR_WIDTH'(r)) begin
        ram_word = mem[r];
        ram_busy = pending_nxt[r];
      end
    end
  end

  // Resolve the value this port will capture: zero for unimplemented or
  // zero-register indices, forwarded write data on a bypass hit, else storage.
  always_comb begin
    idx_ok     = rf_index_ok(32'(raddr), NUM_REGS, ZERO_REG != 0);
    bypass_hit = (BYPASS != 0) && wr_ok && (waddr == raddr);
    rdata_sel  = '0;
    rbusy_sel  = 1'b0;
    if (idx_ok) begin
      rdata_sel = bypass_hit ? wdata : ram_word;
      rbusy_sel = ram_busy;
    end
  end

  // Output registers load only on a read; otherwise they hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
      rbusy <= 1'b0;
    end else if (re) begin
      rdata <= rdata_sel;
      rbusy <= rbusy_sel;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional hardwired x0, write bypass,
// and a pending-write scoreboard for decode-stage RAW hazard detection.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NUM_REGS   = RF_NUM_REGS,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           we,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [NUM_RD-1:0]              re,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rdata,
  output logic [NUM_RD-1:0]              rbusy,
  input  logic                           claim_en,
  input  logic [ADDR_WIDTH-1:0]          claim_addr
);

  // Reject configurations the storage/port decode cannot represent.
  if (NUM_REGS < 1 || NUM_REGS > (1 << ADDR_WIDTH)) begin : g_bad_num_regs
    $error("regfile_mp: NUM_REGS must be in 1..2**ADDR_WIDTH");
  end
  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("regfile_mp: NUM_RD must be in 1..4");
  end

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] mem;
  logic [NUM_REGS-1:0]                 pending;
  logic [NUM_REGS-1:0]                 pending_nxt;
  logic                                wr_ok;
  logic                                claim_ok;

  // Qualify the write and the claim: out-of-range and zero-register
  // targets are silently dropped.
  always_comb begin
    wr_ok    = we && rf_index_ok(32'(waddr), NUM_REGS, ZERO_REG != 0);
    claim_ok = claim_en && rf_index_ok(32'(claim_addr), NUM_REGS, ZERO_REG != 0);
  end

  // Next pending state: a retiring write clears its bit, a new claim sets
  // it, and the claim is applied last so a new producer supersedes the
  // one retiring on the same edge.
  always_comb begin
    pending_nxt = pending;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (wr_ok && (waddr == ADDR_WIDTH'(r))) begin
        pending_nxt[r] = 1'b0;
      end
      if (claim_ok && (claim_addr == ADDR_WIDTH'(r))) begin
        pending_nxt[r] = 1'b1;
      end
    end
  end

  // Register storage; cleared on reset, written by accepted writes only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_ok && (waddr == ADDR_WIDTH'(r))) begin
          mem[r] <= wdata;
        end
      end
    end
  end

  // Scoreboard flops track which registers have an in-flight producer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // One independent read port per requested index.
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    regfile_read_port #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS)
    ) u_port (
      .clk         (clk),
      .rst_n       (rst_n),
      .re          (re[gi]),
      .raddr       (raddr[gi*ADDR_WIDTH +: ADDR_WIDTH]),
      .mem         (mem),
      .pending_nxt (pending_nxt),
      .wr_ok       (wr_ok),
      .waddr       (waddr),
      .wdata       (wdata),
      .rdata       (rdata[gi*DATA_WIDTH +: DATA_WIDTH]),
      .rbusy       (rbusy[gi])
    );
  end

endmodule
